// File: rtl/gsu_pkg.sv
// Shared constants, state encoding and cache-window helpers for the GSU cache fill block.
// Latency: none; this is a package.
// Backpressure: none; this is a package.
package gsu_pkg;

  localparam int LINES       = 32;
  localparam int LINE_BYTES  = 16;
  localparam int CACHE_AW    = 9;
  localparam int CACHE_BYTES = LINES * LINE_BYTES;   // cache window size in bytes
  localparam int LINE_AW     = $clog2(LINE_BYTES);   // byte-in-line address width
  localparam int IDX_W       = $clog2(LINES);        // line index width
  localparam int PC_W        = 16;
  localparam int ROM_AW      = 24;
  localparam int LBASE_W     = ROM_AW - LINE_AW;     // line-aligned ROM address width

  // One-hot state encoding.
  localparam logic [4:0] ST_IDLE     = 5'b00001;
  localparam logic [4:0] ST_WAIT_BUS = 5'b00010;
  localparam logic [4:0] ST_REQ      = 5'b00100;
  localparam logic [4:0] ST_WRITE    = 5'b01000;
  localparam logic [4:0] ST_DONE     = 5'b10000;

  typedef enum logic [4:0] {
    S_IDLE     = ST_IDLE,
    S_WAIT_BUS = ST_WAIT_BUS,
    S_REQ      = ST_REQ,
    S_WRITE    = ST_WRITE,
    S_DONE     = ST_DONE
  } state_t;

  // Offset of a PC from the cache base, modulo 2^16 so the window may wrap.
  function automatic logic [PC_W-1:0] win_off(input logic [PC_W-1:0]         pc,
                                              input logic [PC_W-LINE_AW-1:0] cbr);
    return pc - {cbr, {LINE_AW{1'b0}}};
  endfunction

  function automatic logic in_window(input logic [PC_W-1:0] off);
    return off < PC_W'(CACHE_BYTES);
  endfunction

endpackage

// File: rtl/gsu_cache_fill_if.sv
// ROM read bus plus cache RAM write port used by the GSU cache fill engine.
// Latency: none; wires only. master = fill engine, slave = ROM bus / cache RAM side.
// Backpressure: rom_req is held by the master until the slave returns a one-cycle rom_ack.
interface gsu_cache_fill_if;
  import gsu_pkg::*;

  logic                rom_req;    // read request, held until rom_ack
  logic [ROM_AW-1:0]   rom_addr;   // ROM byte address
  logic                rom_ack;    // one-cycle strobe, rom_data valid
  logic [7:0]          rom_data;   // ROM read data
  logic                cw_en;      // cache RAM write strobe
  logic [CACHE_AW-1:0] cw_addr;    // cache RAM write address
  logic [7:0]          cw_data;    // cache RAM write data

  modport master (
    output rom_req, rom_addr, cw_en, cw_addr, cw_data,
    input  rom_ack, rom_data
  );

  modport slave (
    input  rom_req, rom_addr, cw_en, cw_addr, cw_data,
    output rom_ack, rom_data
  );

endinterface

// File: rtl/gsu_cache_flags.sv
// Line-valid flag register for the GSU instruction cache: two set ports and a clear-all.
// Latency: a set or clear is visible on flags_o the cycle after it is presented.
// Backpressure: none; every request is taken. clr_all_i beats both sets in the same cycle.
// Ports: clkin, rst_n; clr_all_i; fill_set_i/fill_idx_i; snes_set_i/snes_idx_i; flags_o.
module gsu_cache_flags
  import gsu_pkg::*;
(
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             clr_all_i,
  input  logic             fill_set_i,
  input  logic [IDX_W-1:0] fill_idx_i,
  input  logic             snes_set_i,
  input  logic [IDX_W-1:0] snes_idx_i,
  output logic [LINES-1:0] flags_o
);

  logic [LINES-1:0] flags_q, flags_d;

  always_comb begin
    flags_d = flags_q;
    if (fill_set_i) flags_d[fill_idx_i] = 1'b1;
    if (snes_set_i) flags_d[snes_idx_i] = 1'b1;
    // A flush seen in the same cycle as a set still leaves every line invalid.
    if (clr_all_i)  flags_d = '0;
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags_o = flags_q;

endmodule

// File: rtl/gsu_cache_fill.sv
// GSU instruction cache write side: fetches a missed 16-byte line over the ROM bus into cache RAM.
// Latency: miss_req to fill_done is 35 cycles with ron=1 and rom_ack in the request cycle; 1 cycle for hit/out-of-window.
// Backpressure: waits for ron before requesting, holds rom_req until rom_ack; miss_req ignored while busy.
// Ports: clkin, rst_n; miss_req/miss_pc/pbr/cbr from the core; ron bus ownership; flush; snes_flag_set/idx;
//        bus (ROM read + cache write, master side); flags; fill_done/fill_oor; busy.
module gsu_cache_fill
  import gsu_pkg::*;
(
  input  logic                   clkin,
  input  logic                   rst_n,
  input  logic                   miss_req,
  input  logic [PC_W-1:0]        miss_pc,
  input  logic [7:0]             pbr,
  input  logic [PC_W-LINE_AW-1:0] cbr,
  input  logic                   ron,
  input  logic                   flush,
  input  logic                   snes_flag_set,
  input  logic [IDX_W-1:0]       snes_flag_idx,
  gsu_cache_fill_if.master       bus,
  output logic [LINES-1:0]       flags,
  output logic                   fill_done,
  output logic                   fill_oor,
  output logic                   busy
);

  state_t               state_q, state_d;
  logic [LINE_AW-1:0]   cnt_q,   cnt_d;    // byte within the line
  logic [LBASE_W-1:0]   base_q,  base_d;   // line-aligned ROM address
  logic [IDX_W-1:0]     line_q,  line_d;   // cache line being filled
  logic [7:0]           data_q,  data_d;   // byte captured on rom_ack
  logic                 abort_q, abort_d;  // flush seen while a bus cycle was open
  logic                 done_q,  done_d;
  logic                 oor_q,   oor_d;

  logic [PC_W-1:0]      miss_off;
  logic                 miss_in_win;
  logic [IDX_W-1:0]     miss_idx;
  logic                 miss_hit;

  assign miss_off    = win_off(miss_pc, cbr);
  assign miss_in_win = in_window(miss_off);
  assign miss_idx    = miss_off[CACHE_AW-1:LINE_AW];
  // A flush in the same cycle invalidates the line, so it cannot count as a hit.
  assign miss_hit    = flags[miss_idx] && !flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    line_d  = line_q;
    data_d  = data_q;
    abort_d = abort_q;
    done_d  = 1'b0;
    oor_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The core holds miss_req until it sees fill_done; the cycle fill_done is
        // up is the stale tail of the request just answered, so skip it.
        if (miss_req && !done_q) begin
          if (!miss_in_win) begin
            done_d = 1'b1;
            oor_d  = 1'b1;
          end else if (miss_hit) begin
            done_d = 1'b1;
          end else begin
            base_d  = {pbr, miss_pc[PC_W-1:LINE_AW]};
            line_d  = miss_idx;
            cnt_d   = '0;
            abort_d = 1'b0;
            state_d = S_WAIT_BUS;
          end
        end
      end

      S_WAIT_BUS: begin
        if (flush)    state_d = S_IDLE;
        else if (ron) state_d = S_REQ;
      end

      S_REQ: begin
        // A flush never abandons an open bus cycle: remember it and finish the read.
        if (flush) abort_d = 1'b1;
        if (bus.rom_ack) begin
          if (flush || abort_q) begin
            abort_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            data_d  = bus.rom_data;
            state_d = S_WRITE;
          end
        end else if (!ron) begin
          // Bus taken away before the ack: no cycle is open any more, so a pending
          // abort can complete now; otherwise refetch the same byte later.
          if (flush || abort_q) begin
            abort_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_BUS;
          end
        end
      end

      S_WRITE: begin
        // The write strobe of this cycle is already out; flush stops any further ones.
        if (flush) begin
          state_d = S_IDLE;
        end else if (&cnt_q) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_REQ;
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      line_q  <= '0;
      data_q  <= '0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      line_q  <= line_d;
      data_q  <= data_d;
      abort_q <= abort_d;
      done_q  <= done_d;
      oor_q   <= oor_d;
    end
  end

  // Outputs decode straight from registered state, so reset drives them to zero at once.
  assign bus.rom_req  = (state_q == S_REQ);
  assign bus.rom_addr = {base_q, cnt_q};
  assign bus.cw_en    = (state_q == S_WRITE);
  assign bus.cw_addr  = {line_q, cnt_q};
  assign bus.cw_data  = data_q;
  assign fill_done    = done_q;
  assign fill_oor     = oor_q;
  assign busy         = (state_q != S_IDLE);

  gsu_cache_flags u_flags (
    .clkin      (clkin),
    .rst_n      (rst_n),
    .clr_all_i  (flush),
    .fill_set_i (state_q == S_DONE),
    .fill_idx_i (line_q),
    .snes_set_i (snes_flag_set),
    .snes_idx_i (snes_flag_idx),
    .flags_o    (flags)
  );

endmodule
